// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package adder_seq_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder_4bit.sv
// Combinational 4-bit ripple adder with carry in/out.
module full_adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/adder_sequencer.sv
// Nibble-serial add/subtract: one shared 4-bit adder walks the operands
// LSB nibble first, then publishes sum/cout/ovf on entry to DONE.
module adder_sequencer
   import adder_seq_pkg::*;
#(
   parameter int unsigned NIBBLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      sub,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   output logic                      busy,
   output logic                      done,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                      cout,
   output logic                      ovf
);

   localparam int unsigned W        = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  carry_q, carry_d;
   logic [W-1:0]          opa_q, opa_d;
   logic [W-1:0]          opb_q, opb_d;
   logic [W-1:0]          res_q, res_d;
   logic [W-1:0]          sum_q, sum_d;
   logic                  cout_q, cout_d;
   logic                  ovf_q, ovf_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [NIBBLE_W-1:0]   fa_a, fa_b, fa_s;
   logic                  fa_co;

   assign fa_a = opa_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];
   assign fa_b = opb_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];

   full_adder_4bit u_fa (
      .a    (fa_a),
      .b    (fa_b),
      .cin  (carry_q),
      .sum  (fa_s),
      .cout (fa_co)
   );

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[32'(idx_q) * NIBBLE_W +: NIBBLE_W] = fa_s;
            carry_d = fa_co;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               sum_d   = res_d;
               cout_d  = fa_co;
               // Same-sign operands producing a different-sign result
               ovf_d   = (fa_a[NIBBLE_W-1] == fa_b[NIBBLE_W-1]) &&
                         (fa_s[NIBBLE_W-1] != fa_a[NIBBLE_W-1]);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer (default 2 nibbles, 8-bit data).
module tb_adder_sequencer;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sub = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   adder_sequencer #(.NIBBLES(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Integer reference: full-width add with ~b+1 for subtraction
   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
      exp_t       e;
      logic [8:0] full;
      logic [7:0] yy;
      yy     = s ? ~y : y;
      full   = 9'(x) + 9'(yy) + 9'(s);
      e.sum  = full[7:0];
      e.cout = full[8];
      e.ovf  = (x[7] == yy[7]) && (full[7] != x[7]);
      return e;
   endfunction

   // Drive one accepting start at the current negedge; returns one negedge later
   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
      a = x; b = y; sub = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int busy_cyc, output bit ok);
      busy_cyc = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) busy_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input exp_t req);
      int   bc;
      bit   ok;
      exp_t e;
      sb.push_back(req);
      send(x, y, s);
      wait_done(bc, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s done_timeout: got no done, required done within 20 cycles", name);
      end
      n_cmp++;
      if (bc !== 2) begin
         n_bad++;
         $display("FAIL %s busy_cycles: got %0d, required 2", name, bc);
      end
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s scoreboard_empty: got empty, required one entry", name);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_bad++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL %s done_pulse: got done=%b busy=%b, required 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, sum, cout, ovf} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  busy, done, sum, cout, ovf);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_add();
      run_op("add_3c_15", 8'h3C, 8'h15, 1'b0, '{sum: 8'h51, cout: 1'b0, ovf: 1'b0});
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
      a = 8'h11; b = 8'h22;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({sum, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL result_hold: got sum=%h cout=%b ovf=%b, required sum=80 cout=0 ovf=1",
                  sum, cout, ovf);
      end
   endtask

   task automatic test_sub();
      run_op("sub_10_20", 8'h10, 8'h20, 1'b1, '{sum: 8'hF0, cout: 1'b0, ovf: 1'b0});
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1});
   endtask

   task automatic test_random();
      logic [7:0] x, y;
      logic       s;
      for (int i = 0; i < 10; i++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         s = 1'($urandom);
         run_op("random", x, y, s, model(x, y, s));
      end
   endtask

   task automatic test_ignore_start();
      exp_t e;
      sb.push_back('{sum: 8'h51, cout: 1'b0, ovf: 1'b0});
      send(8'h3C, 8'h15, 1'b0);
      a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'h0F; b = 8'hF0;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
         n_bad++;
         $display("FAIL ignore_mid_run: got busy=%b done=%b, required 1 0", busy, done);
      end
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({done, sum, cout, ovf} !== {1'b1, e.sum, e.cout, e.ovf}) begin
         n_bad++;
         $display("FAIL ignore_result: got done=%b sum=%h cout=%b ovf=%b, required done=1 sum=%h cout=%b ovf=%b",
                  done, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL ignore_no_restart: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] xs[4] = '{8'h01, 8'h7F, 8'hC0, 8'h33};
      logic [7:0] ys[4] = '{8'h02, 8'h7F, 8'h41, 8'h44};
      logic       ss[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_t       e;
      a = xs[0]; b = ys[0]; sub = ss[0]; start = 1'b1;
      sb.push_back(model(xs[0], ys[0], ss[0]));
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
               n_bad++;
               $display("FAIL b2b_busy op%0d cyc%0d: got busy=%b done=%b, required 1 0", k, c, busy, done);
            end
         end
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b1, e.sum, e.cout, e.ovf}) begin
            n_bad++;
            $display("FAIL b2b_done op%0d: got busy=%b done=%b sum=%h cout=%b ovf=%b, required 0 1 sum=%h cout=%b ovf=%b",
                     k, busy, done, sum, cout, ovf, e.sum, e.cout, e.ovf);
         end
         if (k < 3) begin
            a = xs[k+1]; b = ys[k+1]; sub = ss[k+1];
            sb.push_back(model(xs[k+1], ys[k+1], ss[k+1]));
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL b2b_end: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid_run();
      send(8'h3C, 8'h15, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, sum, cout, ovf} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  busy, done, sum, cout, ovf);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_abort: got busy=%b done=%b, required 0 0", busy, done);
      end
      run_op("after_reset", 8'hA5, 8'h5B, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
